// File: rtl/uc_booth4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uc_booth4                                                     |
// | Purpose  : Control unit for the 4-bit radix-4 (modified Booth) signed    |
// |            multiplier datapath. Sequences clear, operand load, +/-M or   |
// |            +/-2M accumulation and the paired arithmetic shifts, then     |
// |            pulses done when the product is valid.                        |
// | Options  : UC_BOOTH4_ZERO_SKIP_EN - a no-op Booth digit shifts directly  |
// |            in EXAM and skips SH1 (latency 7..9 cycles).                  |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module uc_booth4 (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic q1,
   input  logic q0,
   input  logic q_menos1,
   output logic rst_dp,
   output logic Carga_QM,
   output logic Carga_A,
   output logic Desplaza_AQ,
   output logic MoM2,
   output logic Resta,
   output logic busy,
   output logic done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_LOAD = 3'd2,
      S_EXAM = 3'd3,
      S_SH1  = 3'd4,
      S_SH2  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t r_state;
   logic   r_it;
   logic   r_carga_qm;
   logic   r_shift;
   logic   r_busy;
   logic   r_done;

   logic   w_exam;
   logic   w_add;
   logic   w_mom2;
   logic   w_resta;
   logic   w_skip;

   assign w_exam = (r_state == S_EXAM);

`ifdef UC_BOOTH4_ZERO_SKIP_EN
   // A no-op digit needs no accumulate, so EXAM can perform the first shift itself
   assign w_skip = ~w_add;
`else
   assign w_skip = 1'b0;
`endif

   // Booth radix-4 digit decode of the registered window {q1, q0, q-1}
   always_comb begin
      w_add   = 1'b0;
      w_mom2  = 1'b0;
      w_resta = 1'b0;
      case ({q1, q0, q_menos1})
         3'b001, 3'b010: begin
            w_add = 1'b1;
         end
         3'b011: begin
            w_add  = 1'b1;
            w_mom2 = 1'b1;
         end
         3'b100: begin
            w_add   = 1'b1;
            w_mom2  = 1'b1;
            w_resta = 1'b1;
         end
         3'b101, 3'b110: begin
            w_add   = 1'b1;
            w_resta = 1'b1;
         end
         default: begin
            w_add = 1'b0;
         end
      endcase
   end

   // Sequencer: state, iteration counter and registered Moore strobes for the next state
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_it       <= 1'b0;
         r_carga_qm <= 1'b0;
         r_shift    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_carga_qm <= 1'b0;
         r_shift    <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CLR;
                  r_busy  <= 1'b1;
               end
            end
            S_CLR: begin
               r_state    <= S_LOAD;
               r_carga_qm <= 1'b1;
            end
            S_LOAD: begin
               r_state <= S_EXAM;
               r_it    <= 1'b0;
            end
            S_EXAM: begin
               r_shift <= 1'b1;
               if (w_skip) begin
                  r_state <= S_SH2;
               end else begin
                  r_state <= S_SH1;
               end
            end
            S_SH1: begin
               r_state <= S_SH2;
               r_shift <= 1'b1;
            end
            S_SH2: begin
               if (!r_it) begin
                  r_it    <= 1'b1;
                  r_state <= S_EXAM;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_it    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Adder controls are only meaningful while a digit is being examined
   assign MoM2        = w_exam & w_mom2;
   assign Resta       = w_exam & w_resta;
   assign Carga_A     = w_exam & w_add;
   assign Desplaza_AQ = r_shift | (w_exam & w_skip);
   assign Carga_QM    = r_carga_qm;
   assign busy        = r_busy;
   assign done        = r_done;
   assign rst_dp      = reset & (r_state != S_CLR);

endmodule
`default_nettype wire

// File: tb/tb_uc_booth4.sv
`default_nettype none
// Testbench for uc_booth4: drives the control unit with a behavioural radix-4
// datapath attached and checks strobes, timing and signed products.
module tb_uc_booth4;

`ifdef UC_BOOTH4_ZERO_SKIP_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start, q1, q0, q_menos1;
   logic rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done;
   logic [3:0] mplier, mcand;

   always #5 clk = ~clk;

   uc_booth4 dut (
      .clk(clk), .reset(reset), .start(start),
      .q1(q1), .q0(q0), .q_menos1(q_menos1),
      .rst_dp(rst_dp), .Carga_QM(Carga_QM), .Carga_A(Carga_A),
      .Desplaza_AQ(Desplaza_AQ), .MoM2(MoM2), .Resta(Resta),
      .busy(busy), .done(done)
   );

   // Behavioural multiplier datapath: A (6b), Q (4b), q-1, M and 2M
   logic signed [5:0] dp_a, dp_m, dp_m2;
   logic [3:0] dp_q;
   logic dp_qm1;
   always_ff @(posedge clk) begin
      if (!rst_dp) begin
         dp_a <= '0; dp_m <= '0; dp_m2 <= '0; dp_q <= '0; dp_qm1 <= 1'b0;
      end else if (Carga_QM) begin
         dp_m  <= {{2{mcand[3]}}, mcand};
         dp_m2 <= {mcand[3], mcand, 1'b0};
         dp_q  <= mplier;
      end else if (Carga_A) begin
         dp_a <= Resta ? dp_a - (MoM2 ? dp_m2 : dp_m) : dp_a + (MoM2 ? dp_m2 : dp_m);
      end else if (Desplaza_AQ) begin
         {dp_a, dp_q, dp_qm1} <= {dp_a[5], dp_a, dp_q};
      end
   end
   assign q1 = dp_q[1];
   assign q0 = dp_q[0];
   assign q_menos1 = dp_qm1;

   int total = 0;
   int bad = 0;

   logic [15:0] obs_mom2, obs_resta, obs_carga, obs_desp, obs_busy, obs_rstdp;
   int obs_done_cyc, obs_done_n;
   logic obs_overlap;
   logic [7:0] obs_result;

   // Booth digit k of multiplier b: b[2k] + b[2k-1] - 2*b[2k+1]
   function automatic int bdig(input logic [3:0] b, input int k);
      int lo;
      lo = 0;
      if (k > 0) lo = int'(b[2*k-1]);
      return int'(b[2*k]) + lo - 2 * int'(b[2*k+1]);
   endfunction

   function automatic int step_len(input int d);
      return (ZS && d == 0) ? 2 : 3;
   endfunction

   function automatic logic [7:0] sprod(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[7:0];
   endfunction

   // Runs one multiplication, recording outputs per cycle (cycle 1 = CLR).
   // mode 0: start pulsed; 1: start held high; 2: start toggled while busy, high at end.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int mode);
      obs_mom2 = '0; obs_resta = '0; obs_carga = '0; obs_desp = '0;
      obs_busy = '0; obs_rstdp = '0;
      obs_done_cyc = -1; obs_done_n = 0; obs_overlap = 1'b0; obs_result = 8'hxx;
      mplier = a; mcand = b;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         obs_mom2[c] = MoM2; obs_resta[c] = Resta; obs_carga[c] = Carga_A;
         obs_desp[c] = Desplaza_AQ; obs_busy[c] = busy; obs_rstdp[c] = rst_dp;
         if (Carga_A && Desplaza_AQ) obs_overlap = 1'b1;
         if (done) begin
            obs_done_n++;
            if (obs_done_cyc < 0) begin
               obs_done_cyc = c;
               obs_result = {dp_a[3:0], dp_q};
            end
         end
         if (mode == 0) start = 1'b0;
         else if (mode == 2) start = (obs_done_cyc >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (obs_done_cyc >= 0 && c > obs_done_cyc) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mplier = '0; mcand = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done} !== 8'h00) begin
         bad++;
         $display("FAIL reset_held: outputs=%b expected=%b",
                  {rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done}, 8'h00);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (rst_dp !== 1'b1) begin
         bad++;
         $display("FAIL rst_dp_mirror: rst_dp=%b expected=1", rst_dp);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done} !== 8'h80) begin
         bad++;
         $display("FAIL idle_outputs: outputs=%b expected=%b",
                  {rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done}, 8'h80);
      end
   endtask

   task automatic test_decode_6x7();
      run_op(4'd6, 4'd7, 0);
      total++;
      if ({obs_mom2[3], obs_resta[3], obs_carga[3]} !== 3'b111) begin
         bad++;
         $display("FAIL decode_it0: MoM2/Resta/Carga_A=%b expected=111",
                  {obs_mom2[3], obs_resta[3], obs_carga[3]});
      end
      total++;
      if ({obs_mom2[6], obs_resta[6], obs_carga[6]} !== 3'b101) begin
         bad++;
         $display("FAIL decode_it1: MoM2/Resta/Carga_A=%b expected=101",
                  {obs_mom2[6], obs_resta[6], obs_carga[6]});
      end
      total++;
      if (obs_done_cyc != 9 || obs_result !== 8'h2A) begin
         bad++;
         $display("FAIL done_6x7: cycle=%0d result=%h expected cycle=9 result=2a",
                  obs_done_cyc, obs_result);
      end
   endtask

   task automatic test_signed_products();
      logic [3:0] ta [3] = '{4'hC, 4'h8, 4'h3};
      logic [3:0] tb [3] = '{4'h7, 4'h8, 4'h5};
      logic [7:0] te [3] = '{8'hE4, 8'h40, 8'h0F};
      int exp_cyc;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tb[i], 0);
         exp_cyc = 3 + step_len(bdig(ta[i], 0)) + step_len(bdig(ta[i], 1));
         total++;
         if (obs_result !== te[i] || obs_done_cyc != exp_cyc || obs_done_n != 1) begin
            bad++;
            $display("FAIL signed_%0d: result=%h cycle=%0d pulses=%0d expected result=%h cycle=%0d pulses=1",
                     i, obs_result, obs_done_cyc, obs_done_n, te[i], exp_cyc);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] a, b;
      int d [2];
      int e [2];
      int exp_cyc;
      logic stray;
      for (int n = 0; n < 12; n++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         run_op(a, b, 0);
         d[0] = bdig(a, 0); d[1] = bdig(a, 1);
         e[0] = 3; e[1] = 3 + step_len(d[0]);
         exp_cyc = e[1] + step_len(d[1]);
         total++;
         if (obs_result !== sprod(a, b) || obs_done_cyc != exp_cyc) begin
            bad++;
            $display("FAIL random_prod %0d*%0d: result=%h cycle=%0d expected result=%h cycle=%0d",
                     $signed(a), $signed(b), obs_result, obs_done_cyc, sprod(a, b), exp_cyc);
         end
         for (int k = 0; k < 2; k++) begin
            total++;
            if ({obs_carga[e[k]], obs_mom2[e[k]], obs_resta[e[k]], obs_desp[e[k]]} !==
                {d[k] != 0, d[k] == 2 || d[k] == -2, d[k] < 0, ZS && d[k] == 0}) begin
               bad++;
               $display("FAIL random_exam%0d mplier=%h: CA/MoM2/Resta/Desp=%b expected=%b",
                        k, a, {obs_carga[e[k]], obs_mom2[e[k]], obs_resta[e[k]], obs_desp[e[k]]},
                        {d[k] != 0, d[k] == 2 || d[k] == -2, d[k] < 0, ZS && d[k] == 0});
            end
         end
         stray = obs_overlap;
         for (int c = 1; c <= 15; c++)
            if (c != e[0] && c != e[1] && (obs_mom2[c] | obs_resta[c] | obs_carga[c])) stray = 1'b1;
         total++;
         if (stray !== 1'b0 || obs_busy[exp_cyc + 1] !== 1'b0) begin
            bad++;
            $display("FAIL random_strobes mplier=%h: stray=%b busy_after=%b expected stray=0 busy_after=0",
                     a, stray, obs_busy[exp_cyc + 1]);
         end
      end
   endtask

   task automatic test_start_held();
      run_op(4'd6, 4'd7, 2);
      total++;
      if (obs_result !== 8'h2A || obs_done_cyc != 9 || obs_busy[10] !== 1'b0) begin
         bad++;
         $display("FAIL held_first: result=%h cycle=%0d busy10=%b expected result=2a cycle=9 busy10=0",
                  obs_result, obs_done_cyc, obs_busy[10]);
      end
      run_op(4'd3, 4'd5, 1);
      total++;
      if (obs_rstdp[1] !== 1'b0 || obs_busy[1] !== 1'b1 || obs_result !== 8'h0F) begin
         bad++;
         $display("FAIL held_restart: rst_dp11=%b busy11=%b result=%h expected rst_dp11=0 busy11=1 result=0f",
                  obs_rstdp[1], obs_busy[1], obs_result);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      mplier = 4'd6; mcand = 4'd7;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (Desplaza_AQ !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_sh1: Desplaza_AQ=%b busy=%b expected 1 1", Desplaza_AQ, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done} !== 8'h00) begin
         bad++;
         $display("FAIL mid_reset: outputs=%b expected=%b",
                  {rst_dp, Carga_QM, Carga_A, Desplaza_AQ, MoM2, Resta, busy, done}, 8'h00);
      end
      @(negedge clk);
      reset = 1'b1;
      run_op(4'd2, 4'd3, 0);
      total++;
      if (obs_result !== 8'h06 || obs_done_cyc != 9) begin
         bad++;
         $display("FAIL after_reset_2x3: result=%h cycle=%0d expected result=06 cycle=9",
                  obs_result, obs_done_cyc);
      end
   endtask

   task automatic test_zero_skip();
      int exp_cyc;
      run_op(4'd0, 4'd5, 0);
      exp_cyc = ZS ? 7 : 9;
      total++;
      if (obs_result !== 8'h00 || obs_done_cyc != exp_cyc || obs_done_n != 1) begin
         bad++;
         $display("FAIL zero_mplier: result=%h cycle=%0d pulses=%0d expected result=00 cycle=%0d pulses=1",
                  obs_result, obs_done_cyc, obs_done_n, exp_cyc);
      end
      run_op(4'd6, 4'd7, 0);
      total++;
      if (obs_result !== 8'h2A || obs_done_cyc != 9) begin
         bad++;
         $display("FAIL noskip_6x7: result=%h cycle=%0d expected result=2a cycle=9",
                  obs_result, obs_done_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_decode_6x7();
      test_signed_products();
      test_random();
      test_start_held();
      test_reset_mid();
      test_zero_skip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uc_booth4.md
# uc_booth4

Control unit for the 4-bit radix-4 (modified Booth) signed multiplier. It sits directly upstream of the multiplier datapath (`cd`). It sequences clear, operand load, add/subtract of M or 2M, and the paired arithmetic shifts. It decodes the datapath's `q1`, `q0` and `q_menos1` status bits each iteration and signals completion so `result` can be sampled.

## Interface
- No parameters (operand width fixed at 4 bits, 2 iterations).
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  level, sampled only in IDLE; request a multiplication.
- `q1`, `q0`, `q_menos1`  input  1 each  Booth window from the datapath.
- `rst_dp`  output  1  active-low datapath clear: `rst_dp = reset & (state != CLR)`.
- `Carga_QM`  output  1  load M, 2M and Q from the operand inputs.
- `Carga_A`  output  1  load A with the adder output.
- `Desplaza_AQ`  output  1  one-bit arithmetic right shift of A:Q:q-1.
- `MoM2`  output  1  adder operand select: 0 = M, 1 = 2M.
- `Resta`  output  1  adder mode: 1 = A − operand, 0 = A + operand.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse in DONE; `result` is valid in that cycle and stays valid until the next `start`.

## Operation
- States: IDLE, CLR, LOAD, EXAM, SH1, SH2, DONE. The iteration counter `it` is 1 bit.
- IDLE:
  - all strobes are 0.
  - `start`=1 → CLR.
- CLR:
  - `rst_dp`=0, which clears A, Q, M, M2 and q-1.
  - → LOAD.
- LOAD:
  - `Carga_QM`=1.
  - `it` ← 0.
  - → EXAM.
- EXAM: decode op = {q1, q0, q_menos1}:
  - 000, 111: no-op.
  - 001, 010: +M (`MoM2`=0, `Resta`=0).
  - 011: +2M (`MoM2`=1, `Resta`=0).
  - 100: −2M (`MoM2`=1, `Resta`=1).
  - 101, 110: −M (`MoM2`=0, `Resta`=1).
  - `Carga_A`=1 for any op that is not a no-op.
  - → SH1.
- SH1: `Desplaza_AQ`=1 → SH2.
- SH2: `Desplaza_AQ`=1.
  - `it`=0 → `it` ← 1, → EXAM.
  - `it`=1 → DONE.
- DONE:
  - `done`=1.
  - → IDLE.
- `MoM2` and `Resta` are Mealy outputs, valid only in EXAM. They are 0 in all other states.
- Never assert `Carga_A` and `Desplaza_AQ` in the same cycle.
- `start` outside IDLE is ignored. If `start` is still high when the block returns to IDLE, the next operation begins on the following edge.
- `reset`=0 in any state at a clock edge: next state is IDLE, `it`=0, all strobes 0, `busy`=0, `done`=0. `rst_dp` follows `reset` combinationally.

## Timing
- Cycle 0 is the edge at which IDLE samples `start`=1.
- Cycle 1: CLR. Cycle 2: LOAD.
- Cycles 3–5: iteration 0 (EXAM, SH1, SH2).
- Cycles 6–8: iteration 1 (EXAM, SH1, SH2).
- Cycle 9: DONE.
- Fixed latency is 9 cycles from sampling `start` to `done`. The earliest back-to-back restart is CLR at cycle 11.
- EXAM decode uses the q bits as registered after the preceding LOAD or SH2. There is no combinational path from q bits to state in the same cycle as a shift.

## Configuration
- `UC_BOOTH4_ZERO_SKIP_EN` defined:
  - in EXAM, a no-op (000/111) asserts `Desplaza_AQ`=1 in that cycle and goes straight to SH2, skipping SH1.
  - Latency becomes 9 − (number of no-op iterations): minimum 7, maximum 9.
  - `done` still pulses for exactly one cycle.
- Not defined: fixed 9-cycle latency; EXAM never asserts `Desplaza_AQ`.

## Test plan
- Reset and idle:
  - Stimulus: hold `reset`=0 for 2 cycles, then `reset`=1 with `start`=0.
  - Required: all strobes and `busy`/`done` are 0, and `rst_dp` mirrors `reset`.
- Decode check with `cd` attached, multiplicador=6, multiplicando=7:
  - iteration 0 EXAM: `MoM2`=1, `Resta`=1, `Carga_A`=1.
  - iteration 1 EXAM: `MoM2`=1, `Resta`=0.
  - `done` at cycle 9 with `result`=0x2A.
- Signed products via `cd`:
  - −4×7 → `result`=0xE4.
  - −8×−8 → 0x40.
  - 3×5 → 0x0F.
  - Each with `done` exactly 9 cycles after `start`.
- `start` held high for the whole test:
  - a second operation begins: CLR at cycle 11.
  - `start` toggling during `busy` has no effect on state or strobes.
- Reset mid-operation:
  - Stimulus: `reset`=0 during iteration 1 SH1.
  - Required: next cycle is IDLE with all outputs 0. A following multiplication 2×3 yields 0x06.
- With `UC_BOOTH4_ZERO_SKIP_EN` defined:
  - multiplicador=0 → `done` at cycle 7, `result`=0x00.
  - multiplicador=6 → `done` at cycle 9 (no skips).
